mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I memory stage directly downstream of the execute ALU. It takes the ALU
//  result (effective address or arithmetic result) plus the instruction word and
//  rs2 data, and drives a valid/ready data-memory port for loads and stores.
//  It formats load data (byte/half select, sign/zero extension) and hands one
//  writeback beat per instruction to the register-file write stage.
// PARAMETERS
//  none (datapath fixed at 32 bits; rd fixed at 5 bits)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  ex_valid       in   1   execute stage presents an instruction
//  ex_ready       out  1   stage accepts; high only in IDLE
//  ex_inst        in   32  instruction word; opcode [6:0], funct3 [14:12], rd [11:7]
//  ex_result      in   32  ALU result (address for load/store)
//  ex_rs2         in   32  store data
//  mem_req_valid  out  1   memory request pending
//  mem_req_ready  in   1   memory accepts request
//  mem_addr       out  32  {ex_result[31:2],2'b00}
//  mem_we         out  1   1=store, 0=load
//  mem_wmask      out  4   byte-lane enables (stores); 4'b0000 for loads
//  mem_wdata      out  32  lane-replicated store data
//  mem_rsp_valid  in   1   load data valid
//  mem_rdata      in   32  load data word
//  wb_valid       out  1   one-cycle writeback beat
//  wb_we          out  1   register write enable (0 for stores, rd==0, traps)
//  wb_rd          out  5   destination register
//  wb_data        out  32  writeback value
//  wb_trap        out  1   misaligned-access trap (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req_valid, mem_we, wb_valid, wb_we, wb_trap=0;
//    mem_wmask=0; mem_addr, mem_wdata, wb_rd, wb_data=0.
//  - FSM IDLE/REQ/WAIT. Handshake fires on ex_valid&ex_ready; inst/result/rs2 latched.
//  - IDLE, non-memory opcode: next cycle wb_valid=1, wb_data=ex_result,
//    wb_we=(rd!=0); stays IDLE (1-cycle latency, back-to-back allowed).
//  - IDLE, load (0000011) or store (0100011): -> REQ; mem_req_valid held high,
//    outputs stable until mem_req_ready.
//  - REQ & mem_req_ready: store -> next cycle wb_valid=1, wb_we=0, back to IDLE;
//    load -> WAIT. Response never earlier than cycle after accept; mem_rsp_valid
//    outside WAIT ignored.
//  - WAIT & mem_rsp_valid: next cycle wb_valid=1 with formatted data, -> IDLE.
//  - Store lanes: SB wmask=4'b0001<<a[1:0], wdata={4{rs2[7:0]}};
//    SH wmask=a[1]?1100:0011, wdata={2{rs2[15:0]}}; SW wmask=1111, wdata=rs2.
//  - Load format: LB/LBU select byte a[1:0]; LH/LHU select half a[1];
//    LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. funct3 011/110/111
//    treated as LW.
//  - wb_valid is a single-cycle pulse; downstream always accepts.
//  - Reset mid-operation (REQ/WAIT): immediate IDLE, mem_req_valid drops, no
//    wb beat; late mem_rsp_valid after reset ignored.
// CONFIGURATION
//  - MEM_STAGE_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with
//    a[1:0]!=0, issue no memory request; next cycle wb_valid=1, wb_trap=1,
//    wb_we=0, wb_data=ex_result; stays IDLE.
//  - Undefined: wb_trap tied 0; low address bits beyond the lane select are
//    ignored (SH a=0x...3 behaves as a=0x...2; LW a=0x...1 reads the word).
// TESTING
//  - ADD result 0x1234, rd=5 -> wb_valid next cycle, wb_we=1, wb_rd=5, wb_data=0x1234.
//  - SB rs2=0xAABBCCDD, addr=0x103, mem_req_ready delayed 3 cycles -> req held
//    stable, mem_addr=0x100, wmask=1000, wdata=0xDDDDDDDD; wb beat with wb_we=0.
//  - LB addr=0x202, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU -> 0x00000080.
//  - LH addr=0x2, rdata=0x8001FFFF -> wb_data=0xFFFF8001; rd=0 -> wb_we=0.
//  - Assert rst in WAIT, then pulse mem_rsp_valid -> no wb_valid, ex_ready=1.
//  - LW addr=0x6 with MEM_STAGE_MISALIGN_TRAP_EN -> no mem_req_valid,
//    wb_trap=1, wb_data=0x6.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I load/store stage with valid/ready memory port and writeback beat; MEM_STAGE_MISALIGN_TRAP_EN enables misaligned-access traps
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_rs2,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_trap
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] f3, f3_q;
  logic [4:0] rd, rd_q;
  logic [1:0] a;
  logic [31:0] res_q, wdata, fmt;
  logic [3:0] wmask;
  logic [15:0] half;
  logic [7:0] byte_sel;
  logic is_ld, is_st, is_mem, mis, fire;
  assign f3 = ex_inst[14:12];
  assign rd = ex_inst[11:7];
  assign a = ex_result[1:0];
  assign is_ld = ex_inst[6:0] == 7'b0000011;
  assign is_st = ex_inst[6:0] == 7'b0100011;
  assign is_mem = is_ld | is_st;
  assign ex_ready = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign fire = ex_valid & ex_ready;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis = is_mem & (f3[1] ? |a : f3[0] ? a[0] : 1'b0);
`else
  assign mis = 1'b0;
`endif
  assign wmask = f3[1] ? 4'b1111 : f3[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  assign wdata = f3[1] ? ex_rs2 : f3[0] ? {2{ex_rs2[15:0]}} : {4{ex_rs2[7:0]}};
  assign half = res_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign byte_sel = res_q[0] ? half[15:8] : half[7:0];
  assign fmt = f3_q[1] ? mem_rdata
             : f3_q[0] ? {{16{~f3_q[2] & half[15]}}, half}
             : {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? ((fire & is_mem & ~mis) ? REQ : IDLE)
            : state == REQ ? (mem_req_ready ? (mem_we ? IDLE : WAIT) : REQ)
            : (mem_rsp_valid ? IDLE : WAIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      f3_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_trap <= 1'b0;
    end else begin
      state <= state_n;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_trap <= 1'b0;
      if (fire) begin
        f3_q <= f3;
        rd_q <= rd;
        res_q <= ex_result;
        if (is_mem & ~mis) begin
          mem_addr <= {ex_result[31:2], 2'b00};
          mem_we <= is_st;
          mem_wmask <= is_st ? wmask : 4'b0000;
          mem_wdata <= is_st ? wdata : 32'h0;
        end else begin
          wb_valid <= 1'b1;
          wb_we <= ~mis & (rd != 5'd0);
          wb_trap <= mis;
          wb_rd <= rd;
          wb_data <= ex_result;
        end
      end
      if (state == REQ && mem_req_ready && mem_we) begin
        wb_valid <= 1'b1;
        wb_rd <= rd_q;
        wb_data <= res_q;
      end
      if (state == WAIT && mem_rsp_valid) begin
        wb_valid <= 1'b1;
        wb_we <= rd_q != 5'd0;
        wb_rd <= rd_q;
        wb_data <= fmt;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; honours MEM_STAGE_MISALIGN_TRAP_EN
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 1'b0;
  logic ex_ready;
  logic [31:0] ex_inst = '0, ex_result = '0, ex_rs2 = '0;
  logic mem_req_valid;
  logic mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic mem_we;
  logic [3:0] mem_wmask;
  logic [31:0] mem_wdata;
  logic mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic wb_valid, wb_we, wb_trap;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, OP = 7'b0110011;
  typedef struct packed {
    logic we;
    logic [4:0] rd;
    logic [31:0] data;
    logic trap;
    logic full;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst(ex_inst), .ex_result(ex_result), .ex_rs2(ex_rs2),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_trap(wb_trap)
  );
  always @(negedge clk) begin
    if (wb_valid) begin
      tests = tests + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL wb_unexpected: got beat rd=%0d data=%h, required no beat", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        if (wb_we !== mon_e.we || wb_trap !== mon_e.trap ||
            (mon_e.full && (wb_rd !== mon_e.rd || wb_data !== mon_e.data))) begin
          fails = fails + 1;
          $display("FAIL wb_beat: got we=%b trap=%b rd=%0d data=%h, required we=%b trap=%b rd=%0d data=%h",
                   wb_we, wb_trap, wb_rd, wb_data, mon_e.we, mon_e.trap, mon_e.rd, mon_e.data);
        end
      end
    end
  end
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, op};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic trap, input logic full);
    sb.push_back('{we, rd, data, trap, full});
  endtask
  task automatic issue(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] rs2);
    int n = 0;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_inst = inst;
    ex_result = res;
    ex_rs2 = rs2;
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL issue_timeout: got ex_ready=0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask
  task automatic do_load(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] rdata, input logic [31:0] addr);
    issue(inst, res, 32'h0);
    @(negedge clk);
    chk("ld_req_valid", mem_req_valid, 1);
    chk("ld_we", mem_we, 0);
    chk("ld_wmask", mem_wmask, 0);
    chk("ld_addr", mem_addr, addr);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    chk("ld_wait_noreq", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata = rdata;
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("ld_wb_lat", wb_valid, 1);
  endtask
  task automatic do_store(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] rs2,
                          input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd, input int dly);
    issue(inst, res, rs2);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      chk("st_req_valid", mem_req_valid, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, addr);
      chk("st_wmask", {28'h0, mem_wmask}, {28'h0, wm});
      chk("st_wdata", mem_wdata, wd);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    chk("st_wb_lat", wb_valid, 1);
    chk("st_idle", ex_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_wb", {wb_valid, wb_we, wb_trap, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wbdata", {wb_rd, wb_data[26:0]}, 0);
    rst = 1'b0;
    push(1, 5, 32'h1234, 0, 1);
    issue(mk(OP, 3'b000, 5), 32'h1234, 32'h0);
    @(negedge clk);
    chk("alu_lat", wb_valid, 1);
    chk("alu_noreq", mem_req_valid, 0);
    push(0, 0, 32'h55, 0, 1);
    issue(mk(7'b0010011, 3'b000, 0), 32'h55, 32'h0);
    push(1, 1, 32'hA, 0, 1);
    push(1, 2, 32'hB, 0, 1);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_inst = mk(OP, 3'b000, 1);
    ex_result = 32'hA;
    @(posedge clk);
    #1 ex_inst = mk(OP, 3'b000, 2);
    ex_result = 32'hB;
    @(negedge clk);
    chk("b2b_first", wb_valid, 1);
    chk("b2b_ready", ex_ready, 1);
    @(posedge clk);
    #1 ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second", wb_valid, 1);
    push(0, 0, 0, 0, 0);
    do_store(mk(ST, 3'b000, 0), 32'h103, 32'hAABBCCDD, 32'h100, 4'b1000, 32'hDDDDDDDD, 3);
    push(0, 0, 0, 0, 0);
    do_store(mk(ST, 3'b001, 0), 32'h12, 32'h0000BEEF, 32'h10, 4'b1100, 32'hBEEFBEEF, 0);
    push(0, 0, 0, 0, 0);
    do_store(mk(ST, 3'b010, 0), 32'h20, 32'h11223344, 32'h20, 4'b1111, 32'h11223344, 1);
    push(1, 7, 32'hFFFFFF80, 0, 1);
    do_load(mk(LD, 3'b000, 7), 32'h202, 32'h00800000, 32'h200);
    push(1, 8, 32'h00000080, 0, 1);
    do_load(mk(LD, 3'b100, 8), 32'h202, 32'h00800000, 32'h200);
    push(0, 0, 32'hFFFF8001, 0, 1);
    do_load(mk(LD, 3'b001, 0), 32'h2, 32'h8001FFFF, 32'h0);
    push(1, 6, 32'h0000F00D, 0, 1);
    do_load(mk(LD, 3'b101, 6), 32'h0, 32'h1234F00D, 32'h0);
    push(1, 3, 32'hDEADBEEF, 0, 1);
    do_load(mk(LD, 3'b010, 3), 32'h8, 32'hDEADBEEF, 32'h8);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    push(0, 4, 32'h6, 1, 1);
    issue(mk(LD, 3'b010, 4), 32'h6, 32'h0);
    @(negedge clk);
    chk("trap_lw_noreq", mem_req_valid, 0);
    chk("trap_lw_lat", wb_valid, 1);
    push(0, 9, 32'h3, 1, 1);
    issue(mk(ST, 3'b001, 9), 32'h3, 32'h1234);
    @(negedge clk);
    chk("trap_sh_noreq", mem_req_valid, 0);
    chk("trap_sh_lat", wb_valid, 1);
`else
    push(1, 4, 32'hCAFEBABE, 0, 1);
    do_load(mk(LD, 3'b010, 4), 32'h6, 32'hCAFEBABE, 32'h4);
    push(0, 0, 0, 0, 0);
    do_store(mk(ST, 3'b001, 0), 32'h3, 32'h00001234, 32'h0, 4'b1100, 32'h12341234, 0);
`endif
    issue(mk(LD, 3'b010, 9), 32'h40, 32'h0);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", ex_ready, 1);
    chk("midrst_req", mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h99999999;
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_wb", wb_valid, 0);
    end
    chk("midrst_idle", ex_ready, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
